// File: rtl/jump_sequencer_if.sv
// Bundle between the button/tick/platform sources and the doodler sequencer.
// The driver side (tick logic, platform owner, testbench) uses master; the sequencer uses slave.
interface jump_sequencer_if;
  logic        tick;
  logic        start;
  logic        left;
  logic        right;
  logic [49:0] plat_x;
  logic [49:0] plat_y;
  logic [4:0]  plat_valid;
  logic [9:0]  cx_pos;
  logic [9:0]  cy_pos;
  logic        scroll_pulse;
  logic [3:0]  scroll_dy;
  logic [2:0]  state;
  logic        game_over;
  logic [15:0] score;

  modport master (
    output tick, start, left, right, plat_x, plat_y, plat_valid,
    input  cx_pos, cy_pos, scroll_pulse, scroll_dy, state, game_over, score
  );

  modport slave (
    input  tick, start, left, right, plat_x, plat_y, plat_valid,
    output cx_pos, cy_pos, scroll_pulse, scroll_dy, state, game_over, score
  );
endinterface

// File: rtl/jump_sequencer.sv
// Game-tick sequencer for the doodler: position, rise/fall phases, platform landing,
// scroll requests and game over. Everything advances only on the one-cycle tick strobe.
//
// state | meaning
// IDLE  | waiting for start, character parked at 464/464
// RISE  | moving up (or scrolling the world) for RISE_TICKS ticks
// FALL  | moving down, looking for a platform or the floor
// OVER  | frozen, game_over high, start returns to IDLE
module jump_sequencer #(
  parameter int RISE_TICKS  = 64,
  parameter int RISE_STEP   = 2,
  parameter int FALL_STEP   = 2,
  parameter int X_STEP      = 2,
  parameter int X_MIN       = 160,
  parameter int X_MAX       = 766,
  parameter int CHAR_H      = 50,
  parameter int CHAR_HW     = 15,
  parameter int PLAT_HW     = 50,
  parameter int SCROLL_LINE = 200,
  parameter int FLOOR_Y     = 515
) (
  input logic             clk,
  input logic             rst,
  jump_sequencer_if.slave bus
);

  localparam int NPLAT = 5;
  localparam int CW    = $clog2(RISE_TICKS);
  localparam logic [9:0]  HOME  = 10'd464;
  localparam logic [10:0] RS    = 11'(RISE_STEP);
  localparam logic [10:0] FS    = 11'(FALL_STEP);
  localparam logic [10:0] XS    = 11'(X_STEP);
  localparam logic [10:0] XMIN  = 11'(X_MIN);
  localparam logic [10:0] XMAX  = 11'(X_MAX);
  localparam logic [10:0] CH    = 11'(CHAR_H);
  localparam logic [10:0] REACH = 11'(PLAT_HW + CHAR_HW);
  localparam logic [10:0] SL    = 11'(SCROLL_LINE);
  localparam logic [10:0] FLOOR = 11'(FLOOR_Y);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RISE = 3'd1,
    S_FALL = 3'd2,
    S_OVER = 3'd3
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0]   rise_ctr_q, rise_ctr_d;
  logic            scroll_pulse_q, scroll_pulse_d;
  logic [3:0]      scroll_dy_q, scroll_dy_d;
  logic [15:0]     score_q, score_d;
  logic            game_over_q;

  logic [9:0]        hx;
  logic [10:0]       cx_up;
  logic [10:0]       of, nf, px, py, dx, land_y;
  logic              land;
  logic signed [10:0] rise_try;

  // Saturating horizontal step; right wins when both buttons are held.
  always_comb begin
    hx    = cx_q;
    cx_up = {1'b0, cx_q} + XS;
    if (bus.right)
      hx = (cx_up > XMAX) ? 10'(XMAX) : 10'(cx_up);
    else if (bus.left)
      hx = ({1'b0, cx_q} >= XMIN + XS) ? cx_q - 10'(XS) : 10'(XMIN);
  end

  // Lowest-index platform wins when several catch the feet on the same tick.
  always_comb begin
    of     = {1'b0, cy_q} + CH;
    nf     = of + FS;
    land   = 1'b0;
    land_y = '0;
    px     = '0;
    py     = '0;
    dx     = '0;
    for (int i = 0; i < NPLAT; i++) begin
      px = {1'b0, bus.plat_x[i*10 +: 10]};
      py = {1'b0, bus.plat_y[i*10 +: 10]};
      dx = ({1'b0, cx_q} >= px) ? ({1'b0, cx_q} - px) : (px - {1'b0, cx_q});
      if (!land && bus.plat_valid[i] && of <= py && nf >= py && dx <= REACH) begin
        land   = 1'b1;
        land_y = py;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    rise_ctr_d     = rise_ctr_q;
    scroll_pulse_d = 1'b0;
    scroll_dy_d    = '0;
    score_d        = score_q;
    rise_try       = $signed({1'b0, cy_q}) - $signed(RS);
    case (state_q)
      S_IDLE: if (bus.tick && bus.start) begin
        state_d    = S_RISE;
        rise_ctr_d = '0;
        score_d    = '0;
      end
      S_RISE: if (bus.tick) begin
        cx_d = hx;
        if (rise_try < $signed(SL)) begin
          scroll_pulse_d = 1'b1;
          scroll_dy_d    = 4'(RISE_STEP);
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end else begin
          cy_d = 10'(rise_try);
        end
        rise_ctr_d = rise_ctr_q + 1'b1;
        if (rise_ctr_q == CW'(RISE_TICKS - 1)) state_d = S_FALL;
      end
      S_FALL: if (bus.tick) begin
        cx_d = hx;
        if (land) begin
          cy_d       = 10'(land_y - CH);
          state_d    = S_RISE;
          rise_ctr_d = '0;
        end else if (nf >= FLOOR) begin
          state_d = S_OVER;
        end else begin
          cy_d = cy_q + 10'(FS);
        end
      end
      S_OVER: if (bus.tick && bus.start) begin
        state_d = S_IDLE;
        cx_d    = HOME;
        cy_d    = HOME;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cx_q           <= HOME;
      cy_q           <= HOME;
      rise_ctr_q     <= '0;
      scroll_pulse_q <= 1'b0;
      scroll_dy_q    <= '0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      rise_ctr_q     <= rise_ctr_d;
      scroll_pulse_q <= scroll_pulse_d;
      scroll_dy_q    <= scroll_dy_d;
      score_q        <= score_d;
      game_over_q    <= (state_d == S_OVER);
    end
  end

  assign bus.cx_pos       = cx_q;
  assign bus.cy_pos       = cy_q;
  assign bus.scroll_pulse = scroll_pulse_q;
  assign bus.scroll_dy    = scroll_dy_q;
  assign bus.state        = state_q;
  assign bus.game_over    = game_over_q;
  assign bus.score        = score_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: default instance plus a SCROLL_LINE=400 instance sharing stimulus;
// expected observations are queued per tick and compared once the tick response is visible.
module tb_jump_sequencer;

  typedef struct packed {
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [2:0]  st;
    logic        sp;
    logic [3:0]  dy;
    logic        go;
    logic [15:0] score;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jump_sequencer_if bus_m ();
  jump_sequencer_if bus_s ();

  assign bus_s.tick       = bus_m.tick;
  assign bus_s.start      = bus_m.start;
  assign bus_s.left       = bus_m.left;
  assign bus_s.right      = bus_m.right;
  assign bus_s.plat_x     = bus_m.plat_x;
  assign bus_s.plat_y     = bus_m.plat_y;
  assign bus_s.plat_valid = bus_m.plat_valid;

  jump_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus_m));
  jump_sequencer #(.SCROLL_LINE(400)) u_scr (.clk(clk), .rst(rst), .bus(bus_s));

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  obs_t got, e;

  function automatic obs_t mk(int cx, int cy, int st, bit sp, int dy, bit go, int score);
    obs_t o;
    o.cx = 10'(cx); o.cy = 10'(cy); o.st = 3'(st); o.sp = sp;
    o.dy = 4'(dy);  o.go = go;      o.score = 16'(score);
    return o;
  endfunction

  function automatic obs_t obs_main();
    return {bus_m.cx_pos, bus_m.cy_pos, bus_m.state, bus_m.scroll_pulse,
            bus_m.scroll_dy, bus_m.game_over, bus_m.score};
  endfunction

  function automatic obs_t obs_scr();
    return {bus_s.cx_pos, bus_s.cy_pos, bus_s.state, bus_s.scroll_pulse,
            bus_s.scroll_dy, bus_s.game_over, bus_s.score};
  endfunction

  function automatic string str(obs_t o);
    return $sformatf("cx=%0d cy=%0d st=%0d sp=%0d dy=%0d go=%0d score=%0d",
                     o.cx, o.cy, o.st, o.sp, o.dy, o.go, o.score);
  endfunction

  // One tick strobe; returns at the negedge after the capturing posedge.
  task automatic pulse(input logic st, input logic l, input logic r);
    @(negedge clk);
    bus_m.start = st; bus_m.left = l; bus_m.right = r; bus_m.tick = 1'b1;
    @(negedge clk);
    bus_m.tick = 1'b0; bus_m.start = 1'b0; bus_m.left = 1'b0; bus_m.right = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    got = obs_main();
    checks++;
    if (got !== mk(464, 464, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_values got %s exp %s", str(got), str(mk(464, 464, 0, 0, 0, 0, 0)));
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(464, 464, 0, 0, 0, 0, 0));
      pulse(1'b0, 1'b0, 1'b0);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL idle_no_start[%0d] got %s exp %s", i, str(got), str(e));
      end
    end
    // start held without tick must be ignored
    bus_m.start = 1'b1;
    repeat (3) @(negedge clk);
    bus_m.start = 1'b0;
    got = obs_main(); checks++;
    if (got !== mk(464, 464, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL idle_start_no_tick got %s exp %s", str(got), str(mk(464, 464, 0, 0, 0, 0, 0)));
    end
  endtask

  task automatic test_rise();
    exp_q.push_back(mk(464, 464, 1, 0, 0, 0, 0));
    pulse(1'b1, 1'b0, 1'b0);
    got = obs_main(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rise_start got %s exp %s", str(got), str(e));
    end
    for (int i = 1; i <= 64; i++) begin
      exp_q.push_back(mk(464, 464 - 2*i, (i == 64) ? 2 : 1, 0, 0, 0, 0));
      pulse(1'b0, 1'b0, 1'b0);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rise[%0d] got %s exp %s", i, str(got), str(e));
      end
    end
  endtask

  task automatic test_land();
    bus_m.plat_x     = 50'd464;
    bus_m.plat_y     = 50'd473;
    bus_m.plat_valid = 5'b00001;
    for (int i = 1; i <= 44; i++) begin
      exp_q.push_back(i == 44 ? mk(464, 423, 1, 0, 0, 0, 0) : mk(464, 336 + 2*i, 2, 0, 0, 0, 0));
      pulse(1'b1, 1'b0, 1'b0);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL land[%0d] got %s exp %s", i, str(got), str(e));
      end
    end
    bus_m.plat_valid = 5'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 got = obs_main();
    checks++;
    if (got !== mk(464, 464, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL rst_in_rise got %s exp %s", str(got), str(mk(464, 464, 0, 0, 0, 0, 0)));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_floor();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (64) pulse(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 65; i++) begin
      exp_q.push_back(i == 65 ? mk(464, 464, 3, 0, 0, 1, 0) : mk(464, 336 + 2*i, 2, 0, 0, 0, 0));
      pulse(1'b0, 1'b0, 1'b0);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL floor[%0d] got %s exp %s", i, str(got), str(e));
      end
    end
    exp_q.push_back(mk(464, 464, 3, 0, 0, 1, 0));
    pulse(1'b0, 1'b1, 1'b1);
    got = obs_main(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL over_frozen got %s exp %s", str(got), str(e));
    end
    exp_q.push_back(mk(464, 464, 0, 0, 0, 0, 0));
    pulse(1'b1, 1'b0, 1'b0);
    got = obs_main(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL over_to_idle got %s exp %s", str(got), str(e));
    end
  endtask

  task automatic test_scroll();
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      if (i <= 32) exp_q.push_back(mk(464, 464 - 2*i, 1, 0, 0, 0, 0));
      else         exp_q.push_back(mk(464, 400, (i == 64) ? 2 : 1, 1, 2, 0, i - 32));
      pulse(1'b0, 1'b0, 1'b0);
      got = obs_scr(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scroll[%0d] got %s exp %s", i, str(got), str(e));
      end
    end
    @(negedge clk);
    got = obs_scr(); checks++;
    if (got !== mk(464, 400, 2, 0, 0, 0, 32)) begin
      errors++;
      $display("FAIL scroll_gap got %s exp %s", str(got), str(mk(464, 400, 2, 0, 0, 0, 32)));
    end
    exp_q.push_back(mk(464, 402, 2, 0, 0, 0, 32));
    pulse(1'b1, 1'b0, 1'b0);
    got = obs_scr(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL start_in_fall got %s exp %s", str(got), str(e));
    end
  endtask

  task automatic test_horiz();
    int ex;
    apply_reset();
    bus_m.plat_x     = {10'd744, 10'd614, 10'd484, 10'd354, 10'd224};
    bus_m.plat_y     = {5{10'd473}};
    bus_m.plat_valid = 5'b11111;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 160; i++) begin
      ex = (464 + 2*i > 766) ? 766 : 464 + 2*i;
      exp_q.push_back(mk(ex, 0, 0, 0, 0, 0, 0));
      pulse(1'b0, 1'b1, 1'b1);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got.cx !== e.cx) begin
        errors++;
        $display("FAIL right_clamp[%0d] got cx=%0d exp cx=%0d", i, got.cx, e.cx);
      end
    end
    for (int i = 1; i <= 310; i++) begin
      ex = (766 - 2*i < 160) ? 160 : 766 - 2*i;
      exp_q.push_back(mk(ex, 0, 0, 0, 0, 0, 0));
      pulse(1'b0, 1'b1, 1'b0);
      got = obs_main(); e = exp_q.pop_front(); checks++;
      if (got.cx !== e.cx) begin
        errors++;
        $display("FAIL left_clamp[%0d] got cx=%0d exp cx=%0d", i, got.cx, e.cx);
      end
    end
    checks++;
    if (bus_m.game_over !== 1'b0) begin
      errors++;
      $display("FAIL bounce_alive got game_over=%0d exp 0", bus_m.game_over);
    end
  endtask

  initial begin
    bus_m.tick = 1'b0; bus_m.start = 1'b0; bus_m.left = 1'b0; bus_m.right = 1'b0;
    bus_m.plat_x = '0; bus_m.plat_y = '0; bus_m.plat_valid = '0;
    #12;
    test_reset();
    test_rise();
    test_land();
    test_rst_mid();
    test_floor();
    test_scroll();
    test_horiz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
